// File: rtl/btn_event_gen.sv
// Button event generator: converts a clean, CLK-synchronous button level into
// single-cycle PRESS/RELEASE/LONG/REPEAT pulses plus a HELD level.
module btn_event_gen #(
    parameter int unsigned TICK_DIV     = 65536,
    parameter int unsigned HOLD_TICKS   = 16,
    parameter int unsigned REPEAT_TICKS = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_LVL,
    output logic PRESS,
    output logic RELEASE,
    output logic LONG,
    output logic REPEAT,
    output logic HELD
);

    localparam int unsigned PW   = $clog2(TICK_DIV);
    localparam int unsigned MAXT = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int unsigned CW   = $clog2(MAXT + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_TICKS - 1);
    localparam logic [CW-1:0] REP_LAST   = CW'(REPEAT_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_REPEATING
    } state_t;

    state_t        state_q, state_d;
    logic          btn_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;
    logic          held_q, held_d;

    logic rise, fall, tick;

    assign rise = BTN_LVL & ~btn_q;
    assign fall = ~BTN_LVL & btn_q;
    assign tick = (presc_q == PRESC_LAST);

    // Prescaler restarts on the press edge so LONG/REPEAT timing is fixed relative to PRESS.
    always_comb begin
        presc_d = presc_q + PW'(1);
        if (rise || tick) begin
            presc_d = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;

        if (rise) begin
            hold_cnt_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    state_d = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (fall) begin
                    release_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (tick && hold_cnt_q == HOLD_LAST) begin
                    long_d     = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = ST_REPEATING;
                end else if (tick) begin
                    hold_cnt_d = hold_cnt_q + CW'(1);
                end
            end
            ST_REPEATING: begin
                if (fall) begin
                    release_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (tick && hold_cnt_q == REP_LAST) begin
                    repeat_d   = 1'b1;
                    hold_cnt_d = '0;
                end else if (tick) begin
                    hold_cnt_d = hold_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        held_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            btn_q      <= 1'b0;
            presc_q    <= '0;
            hold_cnt_q <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            btn_q      <= BTN_LVL;
            presc_q    <= presc_d;
            hold_cnt_q <= hold_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
            held_q     <= held_d;
        end
    end

    assign PRESS   = press_q;
    assign RELEASE = release_q;
    assign LONG    = long_q;
    assign REPEAT  = repeat_q;
    assign HELD    = held_q;

endmodule

// File: tb/tb_btn_event_gen.sv
// Scoreboard bench for btn_event_gen: directed button sequences push expected
// events with their cycle numbers; a negedge monitor pops and compares.
module tb_btn_event_gen;

    localparam int unsigned TD = 4;
    localparam int unsigned HT = 3;
    localparam int unsigned RT = 2;

    localparam logic [3:0] K_PRESS   = 4'b0001;
    localparam logic [3:0] K_RELEASE = 4'b0010;
    localparam logic [3:0] K_LONG    = 4'b0100;
    localparam logic [3:0] K_REPEAT  = 4'b1000;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic BTN_LVL = 1'b0;
    logic PRESS, RELEASE, LONG, REPEAT, HELD;

    btn_event_gen #(
        .TICK_DIV    (TD),
        .HOLD_TICKS  (HT),
        .REPEAT_TICKS(RT)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .BTN_LVL(BTN_LVL),
        .PRESS  (PRESS),
        .RELEASE(RELEASE),
        .LONG   (LONG),
        .REPEAT (REPEAT),
        .HELD   (HELD)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        logic [3:0] kind;
    } ev_t;

    ev_t sb[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: flags overdue expectations, then matches any pulse against the queue head.
    logic [3:0] pulses;
    ev_t        head;
    always @(negedge CLK) begin
        pulses = {REPEAT, LONG, RELEASE, PRESS};
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_event cyc=%0d actual=none required=%b@%0d", cyc, sb[0].kind, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (pulses != 4'b0000) begin
            checks++;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                head = sb.pop_front();
                if (pulses !== head.kind) begin
                    errors++;
                    $display("FAIL event_kind cyc=%0d actual=%b required=%b", cyc, pulses, head.kind);
                end
            end else begin
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d actual=%b required=0000", cyc, pulses);
            end
        end
    end

    task automatic chk(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, actual, required);
        end
    endtask

    task automatic expect_ev(input int c, input logic [3:0] k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int c);
        int guard = 0;
        while (cyc < c && guard < 1000) begin
            @(negedge CLK);
            guard++;
        end
        chk("wait_target", cyc, c);
    endtask

    // Drives the press on a negedge; t is the cycle in which PRESS must be observed.
    task automatic press_at(output int t);
        @(negedge CLK);
        BTN_LVL = 1'b1;
        t = cyc + 1;
        expect_ev(t, K_PRESS);
    endtask

    task automatic drain();
        repeat (6) @(negedge CLK);
        chk("sb_empty", sb.size(), 0);
    endtask

    int t;
    int r;

    initial begin
        // 1: reset state and idle
        repeat (3) @(negedge CLK);
        chk("reset_outputs", int'({PRESS, RELEASE, LONG, REPEAT, HELD}), 0);
        RST = 1'b1;
        repeat (50) @(negedge CLK);
        chk("idle_held", int'(HELD), 0);
        chk("idle_sb_empty", sb.size(), 0);

        // 2: long hold with LONG and REPEATs
        press_at(t);
        expect_ev(t + 12, K_LONG);
        expect_ev(t + 20, K_REPEAT);
        expect_ev(t + 28, K_REPEAT);
        expect_ev(t + 36, K_REPEAT);
        wait_until(t - 1);
        chk("held_before_press", int'(HELD), 0);
        wait_until(t);
        chk("held_at_press", int'(HELD), 1);
        wait_until(t + 39);
        chk("held_long_hold", int'(HELD), 1);
        BTN_LVL = 1'b0;
        expect_ev(t + 40, K_RELEASE);
        wait_until(t + 40);
        chk("held_after_release", int'(HELD), 0);
        drain();

        // 3: single-cycle press
        press_at(t);
        @(negedge CLK);
        chk("held_short", int'(HELD), 1);
        BTN_LVL = 1'b0;
        expect_ev(t + 1, K_RELEASE);
        wait_until(t + 1);
        chk("held_short_release", int'(HELD), 0);
        drain();

        // 4a: release coincides with LONG threshold
        press_at(t);
        wait_until(t + 11);
        BTN_LVL = 1'b0;
        expect_ev(t + 12, K_RELEASE);
        drain();

        // 4b: release coincides with first REPEAT threshold
        press_at(t);
        expect_ev(t + 12, K_LONG);
        wait_until(t + 19);
        BTN_LVL = 1'b0;
        expect_ev(t + 20, K_RELEASE);
        drain();

        // 5: reset mid-hold with the button still down
        press_at(t);
        expect_ev(t + 12, K_LONG);
        wait_until(t + 19);
        RST = 1'b0;
        #1;
        chk("async_reset_outputs", int'({PRESS, RELEASE, LONG, REPEAT, HELD}), 0);
        repeat (3) begin
            @(negedge CLK);
            chk("reset_hold_outputs", int'({PRESS, RELEASE, LONG, REPEAT, HELD}), 0);
        end
        RST = 1'b1;
        r = cyc;
        expect_ev(r + 1, K_PRESS);
        expect_ev(r + 13, K_LONG);
        wait_until(r + 1);
        chk("held_after_reset_press", int'(HELD), 1);
        wait_until(r + 14);
        BTN_LVL = 1'b0;
        expect_ev(r + 15, K_RELEASE);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
